// File: rtl/instr_fetch_mem_if.sv
// Fetch request/response bus between an instruction requester (master) and
// the instruction memory (slave). Valid/ready handshake on both channels.
interface instr_fetch_mem_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_pc;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_instr;
    logic [WIDTH-1:0] rsp_pc;
    logic             rsp_fault;

    modport master (
        output req_valid, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// Instruction memory with a one-cycle fetch pipeline, a program-load port and
// fault-halt. Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module instr_fetch_mem #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 512,
    parameter int BYTE_ADDR = 1,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_mem_if.slave     bus,
    input  logic                 flush,
    input  logic                 load_mode,
    input  logic                 load_we,
    input  logic [AW-1:0]        load_addr,
    input  logic [WIDTH-1:0]     load_data
);
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013);

`ifdef IMEM_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    logic [MW-1:0]    mem_array [DEPTH];

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_instr_reg;
    logic [WIDTH-1:0] rsp_pc_reg;
    logic             rsp_fault_reg;

    logic [WIDTH-1:0] index_full;
    logic [AW-1:0]    mem_idx;
    logic [MW-1:0]    rd_word;
    logic             range_fault;
    logic             align_fault;
    logic             fetch_fault;
    logic             accept;

    assign index_full  = (BYTE_ADDR != 0) ? (bus.req_pc >> 2) : bus.req_pc;
    assign mem_idx     = index_full[AW-1:0];
    assign range_fault = (index_full >= WIDTH'(DEPTH));
    assign align_fault = (BYTE_ADDR != 0) && (bus.req_pc[1:0] != 2'b00);
    assign rd_word     = mem_array[mem_idx];

`ifdef IMEM_PARITY_EN
    // Stored word carries its even-parity bit, so a clean word XORs to zero.
    assign fetch_fault = range_fault || align_fault || (^rd_word);
`else
    assign fetch_fault = range_fault || align_fault;
`endif

    // Flush and load both suppress acceptance so nothing is fetched only to be dropped.
    assign bus.req_ready = (state_reg == ST_RUN) && !load_mode && !flush &&
                           (!rsp_valid_reg || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_instr = rsp_instr_reg;
    assign bus.rsp_pc    = rsp_pc_reg;
    assign bus.rsp_fault = rsp_fault_reg;

    // Memory is never reset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (load_mode && load_we) begin
`ifdef IMEM_PARITY_EN
            mem_array[load_addr] <= {^load_data, load_data};
`else
            mem_array[load_addr] <= load_data;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        if (load_mode) begin
            state_next = ST_LOAD;
        end else if (state_reg == ST_LOAD) begin
            state_next = ST_RUN;
        end else if (flush) begin
            state_next = ST_RUN;
        end else if (accept && fetch_fault) begin
            state_next = ST_HALT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_instr_reg <= '0;
            rsp_pc_reg    <= '0;
            rsp_fault_reg <= 1'b0;
        end else if (load_mode || flush) begin
            rsp_valid_reg <= 1'b0;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_pc_reg    <= bus.req_pc;
            rsp_fault_reg <= fetch_fault;
            rsp_instr_reg <= fetch_fault ? NOP_INSTR : rd_word[WIDTH-1:0];
        end else if (rsp_valid_reg && bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: load, fetch streaming, backpressure,
// fault/halt/flush, reset mid-handshake and the optional parity check.
module tb_instr_fetch_mem;
    logic        clk;
    logic        reset;
    logic        flush;
    logic        load_mode;
    logic        load_we;
    logic [8:0]  load_addr;
    logic [31:0] load_data;

    int n_checks;
    int n_fail;

    logic [31:0] prog [4];

    instr_fetch_mem_if #(.WIDTH(32)) bus ();

    instr_fetch_mem #(.WIDTH(32), .DEPTH(512), .BYTE_ADDR(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .flush     (flush),
        .load_mode (load_mode),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic fault);
        check_value({tag, ".valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check_value({tag, ".instr"}, bus.rsp_instr, instr);
        check_value({tag, ".pc"},    bus.rsp_pc, pc);
        check_value({tag, ".fault"}, {31'd0, bus.rsp_fault}, {31'd0, fault});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prog[0] = 32'h0010_0093;
        prog[1] = 32'h0020_0093;
        prog[2] = 32'h0040_0093;
        prog[3] = 32'h0030_0093;

        reset = 1'b1; flush = 1'b0; load_mode = 1'b0; load_we = 1'b0;
        load_addr = '0; load_data = '0;
        bus.req_valid = 1'b0; bus.req_pc = '0; bus.rsp_ready = 1'b1;
        #3;
        check_value("reset.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_value("reset.rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
        check_value("reset.rsp_instr", bus.rsp_instr, 32'd0);
        check_value("reset.rsp_pc",    bus.rsp_pc, 32'd0);
        check_value("reset.req_ready_run", {31'd0, bus.req_ready}, 32'd1);
        tick();
        reset = 1'b0;

        // Program load
        load_mode = 1'b1; load_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_addr = 9'(i);
            load_data = prog[i];
            #1;
            check_value($sformatf("load%0d.req_ready", i), {31'd0, bus.req_ready}, 32'd0);
            tick();
        end
        load_mode = 1'b0; load_we = 1'b0;
        tick();
        check_value("run.req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Single fetch of index 2
        bus.req_valid = 1'b1; bus.req_pc = 32'h8;
        tick();
        bus.req_valid = 1'b0;
        check_rsp("fetch8", prog[2], 32'h8, 1'b0);

        // Streaming fetch 0x0..0xC
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1; bus.req_pc = 32'(i * 4);
            tick();
            check_rsp($sformatf("stream%0d", i), prog[i], 32'(i * 4), 1'b0);
        end

        // Backpressure: response for 0xC held
        bus.rsp_ready = 1'b0; bus.req_pc = 32'h4;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_value($sformatf("stall%0d.req_ready", i), {31'd0, bus.req_ready}, 32'd0);
            tick();
            check_rsp($sformatf("stall%0d", i), prog[3], 32'hC, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check_value("release.req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check_rsp("release", prog[1], 32'h4, 1'b0);
        tick();
        check_value("drain.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

        // Misaligned fetch faults and halts
        bus.req_valid = 1'b1; bus.req_pc = 32'h6;
        tick();
        bus.req_valid = 1'b0;
        check_rsp("misalign", 32'h13, 32'h6, 1'b1);
        check_value("halt.req_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check_value("halt_done.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_value("halt_done.req_ready", {31'd0, bus.req_ready}, 32'd0);
        flush = 1'b1;
        #1;
        check_value("flush.req_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check_value("after_flush.req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Out-of-range fetch, then flush drops the pending fault response
        bus.req_valid = 1'b1; bus.req_pc = 32'h800;
        tick();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check_rsp("range", 32'h13, 32'h800, 1'b1);
        check_value("range.req_ready", {31'd0, bus.req_ready}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        check_value("flush_drop.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_value("flush_drop.req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Reset mid-handshake
        bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_pc = 32'h8;
        tick();
        bus.req_valid = 1'b0;
        check_value("pre_reset.rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_value("async_reset.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_value("async_reset.rsp_pc",    bus.rsp_pc, 32'd0);
        check_value("async_reset.rsp_instr", bus.rsp_instr, 32'd0);
        tick();
        reset = 1'b0;
        bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_pc = 32'h8;
        #1;
        check_value("post_reset.req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check_rsp("post_reset", prog[2], 32'h8, 1'b0);
        tick();

        // Parity corruption of index 1
`ifdef IMEM_PARITY_EN
        dut.mem_array[1][32] = ~dut.mem_array[1][32];
        bus.req_valid = 1'b1; bus.req_pc = 32'h4;
        tick();
        bus.req_valid = 1'b0;
        check_rsp("parity", 32'h13, 32'h4, 1'b1);
`else
        bus.req_valid = 1'b1; bus.req_pc = 32'h4;
        tick();
        bus.req_valid = 1'b0;
        check_rsp("parity", prog[1], 32'h4, 1'b0);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
